// File: rtl/lmsm_sequencer_if.sv
// lmsm_sequencer_if: memory request/acknowledge bus between the LM/SM
// sequencer (master) and the memory port (slave).
interface lmsm_sequencer_if #(
    parameter int DW = 16,
    parameter int AW = 16
);
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/lmsm_sequencer.sv
// lmsm_sequencer: load-multiple / store-multiple engine. Walks the set bits
// of a register mask (ascending or descending) and moves each register to or
// from consecutive memory words over a req/ack bus with variable latency.
// Optional feature macro: LMSM_WRITEBACK_EN -- adds a WB state that writes
// the final address (base +/- N) into register base_reg before DONE.
module lmsm_sequencer #(
    parameter int NREG = 8,
    parameter int DW   = 16,
    parameter int AW   = 16,
    localparam int LW  = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             proc_rst,
    input  logic             start,
    input  logic             is_store,
    input  logic             dir_desc,
    input  logic [NREG-1:0]  reg_mask,
    input  logic [AW-1:0]    base_addr,
    input  logic [LW-1:0]    base_reg,
    output logic [LW-1:0]    rf_raddr,
    input  logic [DW-1:0]    rf_rdata,
    output logic             rf_wen,
    output logic [LW-1:0]    rf_waddr,
    output logic [DW-1:0]    rf_wdata,
    lmsm_sequencer_if.master bus,
    output logic             busy,
    output logic             done,
    output logic [LW:0]      xfer_count
);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_WB, S_DONE} state_t;

`ifdef LMSM_WRITEBACK_EN
    localparam state_t LAST_STATE = S_WB;
`else
    localparam state_t LAST_STATE = S_DONE;
`endif

    state_t          state, state_nxt;
    logic [NREG-1:0] mask_rem;
    logic [NREG-1:0] mask_next;
    logic [AW-1:0]   addr_cur;
    logic            store_q;
    logic            desc_q;
    logic [LW-1:0]   idx;

`ifdef LMSM_WRITEBACK_EN
    logic [LW-1:0]   base_reg_q;
`else
    logic            unused_base_reg;
    assign unused_base_reg = ^base_reg;
`endif

    // Lowest set bit when ascending, highest when descending.
    function automatic logic [LW-1:0] pick_index(input logic [NREG-1:0] m, input logic desc);
        logic [LW-1:0] r;
        r = '0;
        for (int i = 0; i < NREG; i++) begin
            if (desc) begin
                if (m[i]) r = LW'(i);
            end else begin
                if (m[NREG-1-i]) r = LW'(NREG-1-i);
            end
        end
        return r;
    endfunction

    assign idx        = pick_index(mask_rem, desc_q);
    assign mask_next  = mask_rem & ~(NREG'(1) << idx);
    assign rf_raddr   = idx;

    // State register.
    always_ff @(posedge clk) begin
        if (proc_rst) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // Next-state decode plus the state-derived busy/done flags.
    always_comb begin
        state_nxt = state;
        busy      = (state != S_IDLE);
        done      = (state == S_DONE);
        case (state)
            S_IDLE:  if (start) state_nxt = (reg_mask == '0) ? LAST_STATE : S_ISSUE;
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT:  if (bus.mem_ack) state_nxt = (mask_next == '0) ? LAST_STATE : S_ISSUE;
            S_WB:    state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Operation context, memory request registers and RF write-back port.
    always_ff @(posedge clk) begin
        if (proc_rst) begin
            mask_rem      <= '0;
            addr_cur      <= '0;
            store_q       <= 1'b0;
            desc_q        <= 1'b0;
            xfer_count    <= '0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            rf_wen        <= 1'b0;
            rf_waddr      <= '0;
            rf_wdata      <= '0;
`ifdef LMSM_WRITEBACK_EN
            base_reg_q    <= '0;
`endif
        end else begin
            rf_wen <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mask_rem   <= reg_mask;
                        addr_cur   <= base_addr;
                        store_q    <= is_store;
                        desc_q     <= dir_desc;
                        xfer_count <= '0;
`ifdef LMSM_WRITEBACK_EN
                        base_reg_q <= base_reg;
`endif
                    end
                end
                S_ISSUE: begin
                    bus.mem_req   <= 1'b1;
                    bus.mem_we    <= store_q;
                    bus.mem_addr  <= addr_cur;
                    bus.mem_wdata <= store_q ? rf_rdata : '0;
                end
                S_WAIT: begin
                    if (bus.mem_ack) begin
                        bus.mem_req <= 1'b0;
                        mask_rem    <= mask_next;
                        xfer_count  <= xfer_count + (LW+1)'(1);
                        addr_cur    <= desc_q ? addr_cur - AW'(1) : addr_cur + AW'(1);
                        if (!store_q) begin
                            rf_wen   <= 1'b1;
                            rf_waddr <= idx;
                            rf_wdata <= bus.mem_rdata;
                        end
                    end
                end
`ifdef LMSM_WRITEBACK_EN
                S_WB: begin
                    rf_wen   <= 1'b1;
                    rf_waddr <= base_reg_q;
                    rf_wdata <= DW'(addr_cur);
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lmsm_sequencer.sv
// tb_lmsm_sequencer: randomized + directed bench for lmsm_sequencer with a
// transaction-level reference model (ordered register list, address series,
// expected RF writes and completion cycle).
module tb_lmsm_sequencer;
    localparam int NREG = 8;
    localparam int DW   = 16;
    localparam int AW   = 16;
    localparam int LW   = 3;

    logic            clk = 1'b0;
    logic            proc_rst, start, is_store, dir_desc;
    logic [NREG-1:0] reg_mask;
    logic [AW-1:0]   base_addr;
    logic [LW-1:0]   base_reg, rf_raddr, rf_waddr;
    logic [DW-1:0]   rf_rdata, rf_wdata;
    logic            rf_wen, busy, done;
    logic [LW:0]     xfer_count;

    lmsm_sequencer_if #(.DW(DW), .AW(AW)) bus();

    lmsm_sequencer #(.NREG(NREG), .DW(DW), .AW(AW)) dut (
        .clk(clk), .proc_rst(proc_rst), .start(start), .is_store(is_store),
        .dir_desc(dir_desc), .reg_mask(reg_mask), .base_addr(base_addr),
        .base_reg(base_reg), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .bus(bus), .busy(busy), .done(done), .xfer_count(xfer_count)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] rf [NREG];
    assign rf_rdata = rf[rf_raddr];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
        return (a * 16'h9E37 + 16'h1234) ^ 16'hA5C3;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_req"}, bus.mem_req, 0);
        chk({tag, "_we"}, bus.mem_we, 0);
        chk({tag, "_addr"}, bus.mem_addr, 0);
        chk({tag, "_wdata"}, bus.mem_wdata, 0);
        chk({tag, "_rfwen"}, rf_wen, 0);
        chk({tag, "_rfwaddr"}, rf_waddr, 0);
        chk({tag, "_rfwdata"}, rf_wdata, 0);
        chk({tag, "_raddr"}, rf_raddr, 0);
        chk({tag, "_cnt"}, xfer_count, 0);
    endtask

    // One complete operation; fixed_dly<0 picks random ack delays,
    // rst_at>=0 asserts reset in the first WAIT cycle of that transfer.
    task automatic run_op(input logic [NREG-1:0] m, input logic [AW-1:0] b,
                          input logic st, input logic ds, input logic [LW-1:0] br,
                          input int fixed_dly, input int rst_at);
        int            order[$];
        int            dly[$];
        logic [AW-1:0] e_addr[$];
        logic [LW-1:0] e_wa[$];
        logic [DW-1:0] e_wd[$];
        logic [AW-1:0] g_addr[$];
        logic          g_we[$];
        logic [DW-1:0] g_wd[$];
        logic [LW-1:0] g_wa[$];
        logic [DW-1:0] g_wdat[$];
        int n, total, exp_done, c, req_cnt, cyc, d;
        bit in_req, done_seen, aborted;

        // reference model
        for (int k = 0; k < NREG; k++) begin
            int i;
            i = ds ? NREG-1-k : k;
            if (m[i]) order.push_back(i);
        end
        n = order.size();
        total = 0;
        for (int k = 0; k < n; k++) begin
            d = (fixed_dly >= 0) ? fixed_dly : int'($urandom_range(0, 3));
            dly.push_back(d);
            total += d;
            e_addr.push_back(AW'(ds ? int'(b) - k : int'(b) + k));
            if (!st) begin
                e_wa.push_back(LW'(order[k]));
                e_wd.push_back(mem_val(e_addr[k]));
            end
        end
        exp_done = 2*n + 1 + total;
`ifdef LMSM_WRITEBACK_EN
        exp_done++;
        e_wa.push_back(br);
        e_wd.push_back(DW'(AW'(ds ? int'(b) - n : int'(b) + n)));
`endif

        @(negedge clk);
        reg_mask = m; base_addr = b; is_store = st; dir_desc = ds; base_reg = br;
        start = 1'b1; bus.mem_ack = 1'b0;
        c = 0; req_cnt = 0; cyc = 0; in_req = 0; done_seen = 0; aborted = 0;

        while (!done_seen && !aborted && c < 400) begin
            @(negedge clk);
            c++;
            start = 1'(($urandom_range(0, 1)));
            reg_mask = NREG'($urandom); base_addr = AW'($urandom);
            is_store = 1'($urandom); dir_desc = 1'($urandom); base_reg = LW'($urandom);
            bus.mem_ack = 1'b0;
            bus.mem_rdata = DW'($urandom);
            if (rf_wen) begin
                g_wa.push_back(rf_waddr);
                g_wdat.push_back(rf_wdata);
            end
            chk("busy_during_op", busy, 1);
            if (bus.mem_req) begin
                if (!in_req) begin
                    in_req = 1; cyc = 0;
                    g_addr.push_back(bus.mem_addr);
                    g_we.push_back(bus.mem_we);
                    g_wd.push_back(bus.mem_wdata);
                    if (req_cnt == 0) chk("first_req_cycle", c, 2);
                end else begin
                    chk("hold_addr", bus.mem_addr, g_addr[$]);
                    chk("hold_we", bus.mem_we, g_we[$]);
                    chk("hold_wdata", bus.mem_wdata, g_wd[$]);
                end
                if (rst_at >= 0 && req_cnt == rst_at) begin
                    proc_rst = 1'b1;
                    aborted = 1;
                end else begin
                    d = (req_cnt < n) ? dly[req_cnt] : 0;
                    if (cyc == d) begin
                        bus.mem_ack = 1'b1;
                        bus.mem_rdata = mem_val(bus.mem_addr);
                        in_req = 0;
                        req_cnt++;
                    end
                    cyc++;
                end
            end else if ($urandom_range(0, 3) == 0) begin
                bus.mem_ack = 1'b1;
            end
            if (done) begin
                done_seen = 1;
                chk("done_cycle", c, exp_done);
            end
        end

        if (aborted) begin
            @(negedge clk);
            start = 1'b0; proc_rst = 1'b0; bus.mem_ack = 1'b0;
            chk_all_zero("after_rst");
            chk("rst_rf_writes_before", g_wa.size(), st ? 0 : rst_at);
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                chk("rst_no_rfwen", rf_wen, 0);
                chk("rst_idle", busy, 0);
            end
            return;
        end

        if (!done_seen) chk("done_timeout", 0, 1);

        @(negedge clk);
        start = 1'b0; bus.mem_ack = 1'b0;
        chk("busy_after_done", busy, 0);
        chk("done_pulse_width", done, 0);
        chk("xfer_count", xfer_count, n);
        chk("xfer_num", g_addr.size(), n);
        for (int k = 0; k < n && k < g_addr.size(); k++) begin
            chk("mem_addr", g_addr[k], e_addr[k]);
            chk("mem_we", g_we[k], st);
            chk("mem_wdata", g_wd[k], st ? rf[order[k]] : '0);
        end
        chk("rf_write_num", g_wa.size(), e_wa.size());
        for (int k = 0; k < e_wa.size() && k < g_wa.size(); k++) begin
            chk("rf_waddr", g_wa[k], e_wa[k]);
            chk("rf_wdata", g_wdat[k], e_wd[k]);
        end
    endtask

    task automatic rand_rf();
        for (int i = 0; i < NREG; i++) rf[i] = DW'($urandom);
    endtask

    initial begin
        proc_rst = 1'b1; start = 1'b0; is_store = 1'b0; dir_desc = 1'b0;
        reg_mask = '0; base_addr = '0; base_reg = '0;
        bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        rand_rf();
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        proc_rst = 1'b0;

        // LM ascending, zero-wait memory
        run_op(8'b1001_0010, 16'h0040, 1'b0, 1'b0, 3'd0, 0, -1);
        // SM descending with known register contents
        rf[2] = 16'hAAAA; rf[1] = 16'hBBBB; rf[0] = 16'hCCCC;
        run_op(8'b0000_0111, 16'h0010, 1'b1, 1'b1, 3'd0, 0, -1);
        // wait states on every request
        rand_rf();
        run_op(8'b0010_0001, 16'h0200, 1'b1, 1'b0, 3'd0, 3, -1);
        // zero mask, then address wrap
        run_op(8'b0000_0000, 16'h1234, 1'b0, 1'b0, 3'd0, 0, -1);
        run_op(8'b0000_0011, 16'hFFFF, 1'b0, 1'b0, 3'd0, 0, -1);
        run_op(8'b1100_0000, 16'h0000, 1'b1, 1'b1, 3'd0, 1, -1);
        // reset during the second WAIT of a 4-register LM, then normal op
        run_op(8'b0101_1010, 16'h0300, 1'b0, 1'b0, 3'd0, 1, 1);
        run_op(8'b0000_1100, 16'h0100, 1'b0, 1'b0, 3'd5, 0, -1);

        for (int t = 0; t < 40; t++) begin
            rand_rf();
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_op(NREG'($urandom), AW'($urandom), 1'($urandom), 1'($urandom),
                   LW'($urandom), -1, ($urandom_range(0, 9) == 0) ? 0 : -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end
endmodule
